// File: rtl/reg_arbiter_if.sv
// Requester A/B handshake buses and the register-file port of reg_arbiter.
// The arbiter takes the slave view; requesters and the file model take the master view.
interface reg_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_done;
    logic              a_err;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_done;
    logic              b_err;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] rf_addr;
    logic              rf_wr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_done, a_err, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_done, b_err, b_rdata,
        output rf_addr, rf_wr, rf_wdata,
        input  rf_rdata,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_done, a_err, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_done, b_err, b_rdata,
        input  rf_addr, rf_wr, rf_wdata,
        output rf_rdata,
        input  busy
    );
endinterface

// File: rtl/reg_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 128 x 8 register file.
// Each transaction runs IDLE (sample) -> ACCESS (gnt, file access) -> RESP (done).

module reg_arbiter_port #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gnt_set,
    input  logic              done_set,
    input  logic              err_flag,
    input  logic              capture,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              gnt,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata
);
    logic              gnt_q, gnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        gnt_d   = gnt_set;
        done_d  = done_set;
        err_d   = done_set & err_flag;
        rdata_d = capture ? rf_rdata : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;
endmodule

module reg_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic          clk,
    input  logic          rst,
    reg_arbiter_if.slave  bus
);
    localparam int NUM_PORTS = 2;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    logic [NUM_PORTS-1:0]             req, we;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata, rdata;
    logic [NUM_PORTS-1:0]             gnt, done, err;
    logic [NUM_PORTS-1:0]             gnt_set, done_set, capture;

    state_t            state_q, state_d;
    logic              win_q, win_d;        // last-served / current winner, 0 = A
    logic              cmd_we_q, cmd_we_d;
    logic              cmd_err_q, cmd_err_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              rf_wr_q, rf_wr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              busy_q, busy_d;
    logic              win_sel, sel_in_range;

    assign req   = {bus.b_req, bus.a_req};
    assign we    = {bus.b_we, bus.a_we};
    assign addr  = {bus.b_addr, bus.a_addr};
    assign wdata = {bus.b_wdata, bus.a_wdata};

    // On a tie the requester not served last wins; otherwise the lone requester.
    assign win_sel      = (req[0] && req[1]) ? ~win_q : req[1];
    assign sel_in_range = ({1'b0, addr[win_sel]} < DEPTH_L);

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        cmd_we_d   = cmd_we_q;
        cmd_err_d  = cmd_err_q;
        cmd_addr_d = cmd_addr_q;
        rf_wr_d    = 1'b0;
        rf_wdata_d = '0;
        busy_d     = 1'b0;
        gnt_set    = '0;
        done_set   = '0;
        capture    = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d           = ACCESS;
                    win_d             = win_sel;
                    cmd_we_d          = we[win_sel];
                    cmd_err_d         = ~sel_in_range;
                    cmd_addr_d        = addr[win_sel];
                    rf_wr_d           = we[win_sel] & sel_in_range;
                    rf_wdata_d        = rf_wr_d ? wdata[win_sel] : '0;
                    busy_d            = 1'b1;
                    gnt_set[win_sel]  = 1'b1;
                end
            end
            ACCESS: begin
                state_d         = RESP;
                busy_d          = 1'b1;
                done_set[win_q] = 1'b1;
                // rf_addr is the latched address, so the file's read path is valid here
                capture[win_q]  = ~cmd_we_q & ~cmd_err_q;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= 1'b1;
            cmd_we_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            cmd_addr_q <= '0;
            rf_wr_q    <= 1'b0;
            rf_wdata_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            cmd_we_q   <= cmd_we_d;
            cmd_err_q  <= cmd_err_d;
            cmd_addr_q <= cmd_addr_d;
            rf_wr_q    <= rf_wr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        reg_arbiter_port #(.DATA_W(DATA_W)) u_port (
            .clk      (clk),
            .rst      (rst),
            .gnt_set  (gnt_set[i]),
            .done_set (done_set[i]),
            .err_flag (cmd_err_q),
            .capture  (capture[i]),
            .rf_rdata (bus.rf_rdata),
            .gnt      (gnt[i]),
            .done     (done[i]),
            .err      (err[i]),
            .rdata    (rdata[i])
        );
    end

    assign bus.a_gnt    = gnt[0];
    assign bus.a_done   = done[0];
    assign bus.a_err    = err[0];
    assign bus.a_rdata  = rdata[0];
    assign bus.b_gnt    = gnt[1];
    assign bus.b_done   = done[1];
    assign bus.b_err    = err[1];
    assign bus.b_rdata  = rdata[1];
    assign bus.rf_addr  = cmd_addr_q;
    assign bus.rf_wr    = rf_wr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.busy     = busy_q;
endmodule

// File: doc/reg_arbiter.md
# reg_arbiter

Two-port arbiter and access sequencer for the 128 × 8 register file.
- Accepts single-word read/write transactions from two independent requesters, A and B, using a level-request / done-pulse handshake.
- Serialises the transactions with round-robin priority and drives the register file's single address/write port.
- Returns read data captured from the register file's combinational read path.
- Sits between the bus-side front ends and the register file; it is the only master of that file.

## Interface
Parameters:
- ADDR_W, 7, address width of requester and register-file ports
- DATA_W, 8, data width
- DEPTH, 128, number of implemented registers; addresses ≥ DEPTH are rejected

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  requester A transaction request (level)
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  ADDR_W  A target address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  A command accepted (1-cycle pulse)
- a_done  out  1  A transaction complete (1-cycle pulse)
- a_err  out  1  A address out of range, valid with a_done
- a_rdata  out  DATA_W  A read data, valid with a_done on reads
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_err, b_rdata: same as A, for requester B
- rf_addr  out  ADDR_W  register-file address
- rf_wr  out  1  register-file write strobe
- rf_wdata  out  DATA_W  register-file write data
- rf_rdata  in  DATA_W  register-file combinational read data
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any req is high: select a winner, latch its we/addr/wdata into command registers, update the last-served pointer, go to ACCESS.
  - Otherwise stay in IDLE.
- **Arbitration**
  - Only one req high: that requester wins.
  - Both high: the requester not served last wins.
- **ACCESS**
  - Pulse gnt of the winner.
  - rf_addr = latched address.
  - In-range write: rf_wr = 1, rf_wdata = latched data.
  - In-range read: rf_wr = 0; capture rf_rdata into the winner's rdata register at the end of the cycle.
  - Out-of-range address (≥ DEPTH): rf_wr = 0, no capture, error flag set.
  - Always go to RESP.
- **RESP**
  - Pulse done of the winner; its err reflects the error flag. Go to IDLE.
- rf_wdata = 0 whenever rf_wr = 0. rf_addr holds the last latched address between transactions.
- rdata of each requester holds its last read value until that requester's next successful read; writes and errors leave it unchanged.
- Requester rules:
  - Inputs need only be stable in the IDLE cycle where req is sampled; they may change after gnt.
  - To avoid a repeat transaction, req must be low in the cycle following done.
- The non-winning requester sees no gnt/done/err activity; its req stays pending and is served next.
- **Reset** (asynchronous, any state, including mid-ACCESS):
  - State → IDLE; last-served pointer → B, so A wins the first tie.
  - All outputs 0: gnt, done, err, rdata, rf_addr, rf_wr, rf_wdata, busy.
  - A write in flight when reset asserts is not guaranteed to land.

## Timing
- req sampled in cycle T (IDLE) → ACCESS in T+1 (gnt, rf_wr) → RESP in T+2 (done, rdata, err) → IDLE in T+3.
- Minimum 3 cycles per transaction. Maximum wait for a pending requester is one other transaction: 3 cycles plus its own 3.
- The register file commits a write at the rising edge ending the ACCESS cycle. Any later transaction's read returns the new value.
- gnt, done and err are registered single-cycle pulses. busy is registered and high in ACCESS and RESP.
- Back-to-back operation, with both reqs held continuously, strictly alternates A, B, A, B.

## Test plan
- Reset: assert rst mid-ACCESS of a write → all outputs 0 immediately; after release, first transaction starts from IDLE.
- Single write then read:
  - A writes 0xA5 to 0x12: rf_wr is high exactly 1 cycle with rf_addr = 0x12, a_done 2 cycles after the req sample, a_err = 0.
  - A then reads 0x12: a_rdata = 0xA5 with a_done.
- Simultaneous request after reset, both reqs high in the same cycle:
  - A (write 0x3C @0x01) is served first: a_gnt in T+1.
  - B (read @0x01) is served next: b_gnt at T+4, b_rdata = 0x3C.
- Fairness: both reqs held high for 6 transactions → grants alternate A, B, A, B, A, B with no gap beyond 3 cycles.
- Out of range: with DEPTH = 100, B writes @0x70 → rf_wr stays 0, b_done with b_err = 1; a subsequent read @0x70 gives b_err = 1 and leaves b_rdata unchanged.
- Handshake: A drops req the cycle after a_done → exactly one transaction; A holds req → a second identical transaction follows.
